multicycle_cpu: RTL
===================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 SHALL have parameter NUM_REGS, default 32, register count; legal values 16 or 32.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  begin execution from IDLE.
REQ-007 SHALL have port imem_req_o  output  1  instruction fetch request.
REQ-008 SHALL have port imem_addr_o  output  XLEN  fetch address, equals PC.
REQ-009 SHALL have port imem_valid_i  input  1  fetch data valid.
REQ-010 SHALL have port imem_data_i  input  32  fetched instruction.
REQ-011 SHALL have ports rf_we_o (1), rf_waddr_o (5), rf_wdata_o (XLEN), all outputs: register write-back observation.
REQ-012 SHALL have ports instret_o (XLEN), busy_o (1), halt_o (1), illegal_o (1), all outputs.

Function
REQ-013 SHALL implement FSM IDLE, FETCH, DECODE, EXEC, MUL, WB, HALT.
REQ-014 IDLE->FETCH on start_i=1; start_i SHALL be ignored in all other states.
REQ-015 FETCH SHALL hold imem_req_o=1 until imem_valid_i=1, latch imem_data_i that cycle, then go DECODE; zero-wait response is legal.
REQ-016 imem_valid_i outside FETCH SHALL be ignored.
REQ-017 DECODE SHALL read rs1=inst[19:15], rs2=inst[24:20]; x0 SHALL read as 0.
REQ-018 Supported: opcode 0110011 with funct7/funct3 = 0000000/000 ADD, 0100000/000 SUB, 0000000/111 AND, 0000000/110 OR, 0000001/000 MUL; opcode 0010011 funct3 000 ADDI.
REQ-019 Any other encoding, or a register index >= NUM_REGS, SHALL go DECODE->HALT with illegal_o=1 and no write-back.
REQ-020 EXEC SHALL go WB for non-MUL, or MUL for MUL.
REQ-021 MUL SHALL take exactly XLEN cycles (iterative shift-add), result = low XLEN bits of product, then WB.
REQ-022 All arithmetic SHALL wrap modulo 2^XLEN; ADDI immediate inst[31:20] sign-extended to XLEN.
REQ-023 WB SHALL pulse rf_we_o for one cycle with rd=inst[11:7] and result, except rd=0 (no write, rf_we_o=0); then PC += 4 (wrapping), instret_o += 1, go FETCH.
REQ-024 Cycles per non-MUL instruction with zero-wait memory SHALL be 4 (FETCH, DECODE, EXEC, WB); MUL SHALL be 4+XLEN.
REQ-025 HALT SHALL be exited only by reset; halt_o=1 in HALT.
REQ-026 busy_o SHALL be 1 in every state except IDLE and HALT.
REQ-027 Write of rd in WB SHALL be visible to a read in the next instruction's DECODE.

Reset
REQ-028 On rst_i=0, immediately: state IDLE, PC=RESET_PC, instret_o=0, imem_req_o=0, rf_we_o=0, halt_o=0, illegal_o=0, busy_o=0, multiplier cleared.
REQ-029 Register file contents SHALL be reset to 0.
REQ-030 Reset asserted mid-fetch or mid-MUL SHALL abandon the instruction with no write-back.

Structure
REQ-031 Shared package cpu_pkg SHALL hold opcode/funct7/funct3 constants, the FSM state enum and ALU operation enum.
REQ-032 Iterative multiplier SHALL be sub-module mul_iter (start/done handshake, XLEN-parametrised); register file and ALU inline.

Verification
REQ-033 ADDI x1,x0,5 then ADDI x2,x0,-3, zero-wait -> writes x1=5, x2=0xFFFFFFFD, instret_o=2 after 8 cycles from FETCH.
REQ-034 x1=7, x2=6, MUL x3,x1,x2 -> rf_we_o in cycle 4+XLEN with x3=42; x1=0xFFFFFFFF, x2=2 -> x3=0xFFFFFFFE.
REQ-035 ADDI x0,x0,9 -> rf_we_o stays 0, later read of x0 returns 0; SUB x4,x0,1-valued x5 -> x4=0xFFFFFFFF.
REQ-036 imem_valid_i delayed 3 cycles -> imem_req_o held 4 cycles, imem_addr_o stable, instruction latched once.
REQ-037 Opcode 0000011 fetched -> halt_o=1, illegal_o=1, busy_o=0, start_i pulses ignored until reset.
REQ-038 rst_i low during MUL cycle 10 -> no write-back, PC=RESET_PC, state IDLE; start_i restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg -- instruction encodings, FSM states and ALU ops for multicycle_cpu
// Rev 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MUL    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_MUL = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    legal;
        logic    use_imm;
        alu_op_e op;
    } dec_t;

    function automatic dec_t decode_inst(input logic [31:0] inst);
        dec_t d;
        d.legal   = 1'b0;
        d.use_imm = 1'b0;
        d.op      = ALU_ADD;
        if (inst[6:0] == OPC_OP_IMM && inst[14:12] == F3_ADD) begin
            d.legal   = 1'b1;
            d.use_imm = 1'b1;
        end else if (inst[6:0] == OPC_OP) begin
            case ({inst[31:25], inst[14:12]})
                {F7_BASE,   F3_ADD}: begin d.legal = 1'b1; d.op = ALU_ADD; end
                {F7_SUB,    F3_ADD}: begin d.legal = 1'b1; d.op = ALU_SUB; end
                {F7_BASE,   F3_AND}: begin d.legal = 1'b1; d.op = ALU_AND; end
                {F7_BASE,   F3_OR }: begin d.legal = 1'b1; d.op = ALU_OR;  end
                {F7_MULDIV, F3_ADD}: begin d.legal = 1'b1; d.op = ALU_MUL; end
                default: ;
            endcase
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// mul_iter -- iterative shift-add multiplier, one partial product per cycle
// Rev 1.0
// ============================================================================
module mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);
    localparam int CNT_W = $clog2(XLEN + 1);

    logic [XLEN-1:0]  acc_q, mcand_q, mplier_q;
    logic [XLEN-1:0]  acc_d;
    logic [CNT_W-1:0] cnt_q;

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CNT_W'(XLEN);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    // Done flags the final step so the caller can capture acc_d on the same edge.
    assign done_o    = (cnt_q == CNT_W'(1));
    assign product_o = acc_d;

endmodule
`default_nettype wire

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// multicycle_cpu -- small RV-style multicycle core (ADD/SUB/AND/OR/MUL/ADDI)
// Rev 1.0
// ============================================================================
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [31:0]     imem_data_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic [XLEN-1:0] instret_o,
    output logic            busy_o,
    output logic            halt_o,
    output logic            illegal_o
);
    localparam int         RIDX_W = $clog2(NUM_REGS);
    localparam logic [5:0] NREG   = 6'(NUM_REGS);

    state_e          state_q;
    alu_op_e         op_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q, instret_q, op_a_q, op_b_q, result_q;
    logic            imem_req_q, rf_we_q, busy_q, halt_q, illegal_q;
    logic [XLEN-1:0] regs_q [NUM_REGS];

    dec_t            dec;
    logic [4:0]      rs1, rs2, rd;
    logic            idx_ok;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_sext, alu_res, mul_product;
    logic            mul_start, mul_done;

    assign rs1      = inst_q[19:15];
    assign rs2      = inst_q[24:20];
    assign rd       = inst_q[11:7];
    assign dec      = decode_inst(inst_q);
    assign imm_sext = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
    assign idx_ok   = ({1'b0, rs1} < NREG) && ({1'b0, rd} < NREG) &&
                      (dec.use_imm || ({1'b0, rs2} < NREG));
    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1[RIDX_W-1:0]];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2[RIDX_W-1:0]];

    always_comb begin
        alu_res = '0;
        case (op_q)
            ALU_ADD: alu_res = op_a_q + op_b_q;
            ALU_SUB: alu_res = op_a_q - op_b_q;
            ALU_AND: alu_res = op_a_q & op_b_q;
            ALU_OR:  alu_res = op_a_q | op_b_q;
            default: alu_res = '0;
        endcase
    end

    assign mul_start = (state_q == ST_EXEC) && (op_q == ALU_MUL);

    mul_iter #(.XLEN(XLEN)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= ALU_ADD;
            inst_q     <= '0;
            pc_q       <= RESET_PC;
            instret_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            imem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            halt_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
                ST_FETCH: if (imem_valid_i) begin
                    inst_q     <= imem_data_i;
                    imem_req_q <= 1'b0;
                    state_q    <= ST_DECODE;
                end
                ST_DECODE: if (dec.legal && idx_ok) begin
                    op_q    <= dec.op;
                    op_a_q  <= rs1_val;
                    op_b_q  <= dec.use_imm ? imm_sext : rs2_val;
                    state_q <= ST_EXEC;
                end else begin
                    state_q   <= ST_HALT;
                    busy_q    <= 1'b0;
                    halt_q    <= 1'b1;
                    illegal_q <= 1'b1;
                end
                ST_EXEC: if (op_q == ALU_MUL) begin
                    state_q <= ST_MUL;
                end else begin
                    result_q <= alu_res;
                    rf_we_q  <= (rd != 5'd0);
                    state_q  <= ST_WB;
                end
                ST_MUL: if (mul_done) begin
                    result_q <= mul_product;
                    rf_we_q  <= (rd != 5'd0);
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    rf_we_q    <= 1'b0;
                    pc_q       <= pc_q + XLEN'(4);
                    instret_q  <= instret_q + XLEN'(1);
                    imem_req_q <= 1'b1;
                    state_q    <= ST_FETCH;
                end
                ST_HALT: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write lands at the end of WB, ahead of the next instruction's DECODE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (state_q == ST_WB && rf_we_q) begin
            regs_q[rd[RIDX_W-1:0]] <= result_q;
        end
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = pc_q;
    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rd;
    assign rf_wdata_o  = result_q;
    assign instret_o   = instret_q;
    assign busy_o      = busy_q;
    assign halt_o      = halt_q;
    assign illegal_o   = illegal_q;

endmodule
`default_nettype wire
